dma_peripheral_port: RTL and testbench



---
 rtl/dma_port_pkg.sv | 22 ++
 rtl/dma_peripheral_port_sva.sv | 38 +++
 rtl/dma_port_fifo.sv | 68 ++++++
 rtl/dma_peripheral_port.sv | 182 ++++++++++++++++++
 tb/tb_dma_peripheral_port.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_port_pkg.sv
// Shared types and defaults for the DMA peripheral port: one-hot FSM encoding
// and the request-condition rule used by both TX and RX directions.
package dma_port_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_REQ  = 4'b0010,
        ST_XFER = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

    // TX needs enough data buffered, RX needs enough room left.
    function automatic logic req_cond(input logic tx, input int count,
                                      input int depth, input int thresh);
        if (tx) return count >= thresh;
        return (depth - count) >= thresh;
    endfunction

endpackage

// File: rtl/dma_peripheral_port_sva.sv
// Protocol checks bound into dma_peripheral_port: no request while done,
// bus drive only under acknowledge, and every empty pop is flagged.
module dma_peripheral_port_sva
    import dma_port_pkg::*;
(
    input logic   CLK,
    input logic   RESET_N,
    input logic   DREQ,
    input logic   DACK,
    input logic   dbOutEn,
    input logic   w_bus_pop,
    input logic   w_empty,
    input logic   errUnderrun,
    input state_e r_state
);

    a_no_dreq_in_done: assert property (@(posedge CLK) disable iff (!RESET_N)
        (r_state == ST_DONE) |-> !DREQ);

    a_drive_needs_dack: assert property (@(posedge CLK) disable iff (!RESET_N)
        dbOutEn |-> DACK);

    a_empty_pop_flagged: assert property (@(posedge CLK) disable iff (!RESET_N)
        (w_bus_pop && w_empty) |=> errUnderrun);

endmodule

bind dma_peripheral_port dma_peripheral_port_sva u_sva (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .DREQ        (DREQ),
    .DACK        (DACK),
    .dbOutEn     (dbOutEn),
    .w_bus_pop   (w_bus_pop),
    .w_empty     (w_empty),
    .errUnderrun (errUnderrun),
    .r_state     (r_state)
);

// File: rtl/dma_port_fifo.sv
// Synchronous FIFO with simultaneous push/pop, saturating count and a
// look-ahead count for decisions that must see the post-operation fill level.
module dma_port_fifo
    import dma_port_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [AW:0]           o_count,
    output logic [AW:0]           o_count_next
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [AW:0]           w_count_next;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    assign w_pop_ok  = i_pop & (r_count != '0);
    assign w_push_ok = i_push & ((r_count != DEPTH_C) | w_pop_ok);

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok)
            w_count_next = r_count + (AW+1)'(1);
        else if (w_pop_ok && !w_push_ok)
            w_count_next = r_count - (AW+1)'(1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
        end
    end

    // NOTE: storage is deliberately not reset; only pointers and count define
    // validity, and the head is masked by the consumer when empty.
    always_ff @(posedge CLK) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head       = r_mem[r_rd_ptr];
    assign o_full       = (r_count == DEPTH_C);
    assign o_empty      = (r_count == '0);
    assign o_count      = r_count;
    assign o_count_next = w_count_next;

endmodule

// File: rtl/dma_peripheral_port.sv
// Device-side DREQ/DACK responder for one 8237-style DMA channel: FIFO-backed,
// strobe-rising-edge driven, with sticky terminal-count and error flags.
module dma_peripheral_port
    import dma_port_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int THRESHOLD  = 4,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  dirTx,
    input  logic                  demandMode,
    input  logic [DATA_WIDTH-1:0] devData,
    input  logic                  devValid,
    output logic                  devReady,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    input  logic                  rxReady,
    output logic                  DREQ,
    input  logic                  DACK,
    input  logic                  IOR_N,
    input  logic                  IOW_N,
    input  logic                  EOP_N,
    input  logic [DATA_WIDTH-1:0] dbIn,
    output logic [DATA_WIDTH-1:0] dbOut,
    output logic                  dbOutEn,
    output logic                  tcFlag,
    input  logic                  tcClear,
    output logic                  errOverrun,
    output logic                  errUnderrun
);

    state_e                r_state;
    logic                  r_dir;
    logic                  r_dreq;
    logic                  r_tc;
    logic                  r_err_ovr;
    logic                  r_err_und;
    logic                  r_ior_q;
    logic                  r_iow_q;
    logic [DATA_WIDTH-1:0] r_db_q;

    logic                  w_dir;
    logic                  w_ior_done;
    logic                  w_iow_done;
    logic                  w_strobe_done;
    logic                  w_bus_pop;
    logic                  w_bus_push;
    logic                  w_local_push;
    logic                  w_local_pop;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] w_head_q;
    logic                  w_full;
    logic                  w_empty;
    logic [AW:0]           w_count;
    logic [AW:0]           w_count_next;
    logic                  w_cond_now;
    logic                  w_cond_next;

    // Direction is live while idle and frozen for the rest of a transfer.
    assign w_dir = (r_state == ST_IDLE) ? dirTx : r_dir;

    assign w_ior_done    = DACK & ~r_ior_q & IOR_N;
    assign w_iow_done    = DACK & ~r_iow_q & IOW_N;
    assign w_strobe_done = w_dir ? w_ior_done : w_iow_done;
    assign w_bus_pop     = w_ior_done & w_dir;
    assign w_bus_push    = w_iow_done & ~w_dir;
    assign w_local_push  = devValid & w_dir & ~w_full;
    assign w_local_pop   = rxReady & ~w_dir & ~w_empty;

    assign w_fifo_push = w_dir ? w_local_push : w_bus_push;
    assign w_fifo_pop  = w_dir ? w_bus_pop : w_local_pop;
    assign w_fifo_data = w_dir ? devData : r_db_q;

    dma_port_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .i_push       (w_fifo_push),
        .i_data       (w_fifo_data),
        .i_pop        (w_fifo_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_count_next (w_count_next)
    );

    assign w_cond_now  = req_cond(w_dir, int'(w_count), FIFO_DEPTH, THRESHOLD);
    assign w_cond_next = req_cond(w_dir, int'(w_count_next), FIFO_DEPTH, THRESHOLD);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ior_q <= 1'b1;
            r_iow_q <= 1'b1;
            r_db_q  <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_ior_q <= IOR_N;
            r_iow_q <= IOW_N;
            r_db_q  <= dbIn;
            r_dir   <= w_dir;
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch reads the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_dreq  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            if (tcClear) r_tc <= 1'b0;
            if (!EOP_N && DACK) begin
                r_state <= ST_DONE;
                r_dreq  <= 1'b0;
                r_tc    <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_dreq <= 1'b0;
                        if (w_cond_now) r_state <= ST_REQ;
                    end
                    ST_REQ: begin
                        r_dreq <= 1'b1;
                        if (DACK) r_state <= ST_XFER;
                    end
                    // Demand mode re-arms on the post-transfer fill level.
                    ST_XFER: begin
                        if (w_strobe_done) begin
                            if (DACK && demandMode && w_cond_next) begin
                                r_state <= ST_REQ;
                            end else begin
                                r_state <= ST_IDLE;
                                r_dreq  <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_dreq <= 1'b0;
                        if (tcClear) r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_dreq  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A bus write into a full FIFO is only an error if no local pop frees a slot.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_err_ovr <= 1'b0;
            r_err_und <= 1'b0;
        end else begin
            if (w_bus_push && w_full && !w_local_pop) r_err_ovr <= 1'b1;
            if (w_bus_pop && w_empty)                 r_err_und <= 1'b1;
        end
    end

    assign w_head_q    = w_empty ? '0 : w_head;
    assign devReady    = w_dir & ~w_full;
    assign rxData      = w_head_q;
    assign rxValid     = ~w_dir & ~w_empty;
    assign DREQ        = r_dreq;
    assign dbOut       = w_head_q;
    assign dbOutEn     = DACK & ~IOR_N & w_dir;
    assign tcFlag      = r_tc;
    assign errOverrun  = r_err_ovr;
    assign errUnderrun = r_err_und;

endmodule

// File: tb/tb_dma_peripheral_port.sv
// Directed-sequence bench for dma_peripheral_port with random payloads checked
// against a queue model of the FIFO and sticky-flag rules.
module tb_dma_peripheral_port;
    import dma_port_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TH    = 4;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          dirTx, demandMode, devValid, rxReady, DACK;
    logic          IOR_N, IOW_N, EOP_N, tcClear;
    logic [DW-1:0] devData, dbIn;
    logic          devReady, rxValid, DREQ, dbOutEn, tcFlag, errOverrun, errUnderrun;
    logic [DW-1:0] rxData, dbOut;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] mq[$];
    logic          m_ovr = 1'b0;
    logic          m_und = 1'b0;

    always #5 CLK = ~CLK;

    dma_peripheral_port #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .THRESHOLD(TH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .dirTx(dirTx), .demandMode(demandMode),
        .devData(devData), .devValid(devValid), .devReady(devReady),
        .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
        .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
        .dbIn(dbIn), .dbOut(dbOut), .dbOutEn(dbOutEn), .tcFlag(tcFlag),
        .tcClear(tcClear), .errOverrun(errOverrun), .errUnderrun(errUnderrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_local(input logic [DW-1:0] d);
        devValid = 1'b1;
        devData  = d;
        tick();
        devValid = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(d);
    endtask

    task automatic ior_pulse(input string tag);
        logic [DW-1:0] e;
        IOR_N = 1'b0;
        #1;
        e = (mq.size() > 0) ? mq[0] : '0;
        check({tag, "_dbout"}, 32'(dbOut), 32'(e));
        check({tag, "_oe"}, 32'(dbOutEn), 32'(DACK & dirTx));
        tick();
        IOR_N = 1'b1;
        tick();
        if (DACK && dirTx) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else m_und = 1'b1;
        end
    endtask

    task automatic iow_pulse(input logic [DW-1:0] d);
        dbIn  = d;
        IOW_N = 1'b0;
        tick();
        IOW_N = 1'b1;
        tick();
        if (DACK && !dirTx) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovr = 1'b1;
        end
    endtask

    task automatic wait_dreq(input string tag);
        int n = 0;
        while (DREQ !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(DREQ), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; dirTx = 1'b1; demandMode = 1'b0; devValid = 1'b0;
        rxReady = 1'b0; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
        tcClear = 1'b0; devData = '0; dbIn = '0;

        // Reset values
        #12;
        check("rst_dreq", 32'(DREQ), 0);
        check("rst_oe", 32'(dbOutEn), 0);
        check("rst_dbout", 32'(dbOut), 0);
        check("rst_tc", 32'(tcFlag), 0);
        check("rst_ovr", 32'(errOverrun), 0);
        check("rst_und", 32'(errUnderrun), 0);
        check("rst_devready", 32'(devReady), 1);
        check("rst_rxvalid", 32'(rxValid), 0);
        RESET_N = 1'b1;
        tick();

        // TX single mode: threshold, registered DREQ, one read
        for (int i = 0; i < 4; i++) push_local(8'(8'hA1 + i));
        check("tx_dreq_pre", 32'(DREQ), 0);
        tick();
        check("tx_state_req", 32'(dut.r_state), 32'(ST_REQ));
        check("tx_dreq_lag", 32'(DREQ), 0);
        tick();
        check("tx_dreq_up", 32'(DREQ), 1);
        DACK = 1'b1;
        tick();
        ior_pulse("tx1");
        check("tx1_dreq_drop", 32'(DREQ), 0);
        check("tx1_count", 32'(dut.w_count), 32'(mq.size()));
        DACK = 1'b0;
        tick();
        check("tx1_dreq_stay", 32'(DREQ), 0);

        // TX demand mode: DREQ held until fill drops below threshold
        demandMode = 1'b1;
        for (int i = 0; i < 5; i++) push_local(8'($urandom));
        wait_dreq("dem_dreq");
        DACK = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ior_pulse("dem");
            check("dem_dreq", 32'(DREQ), 32'(mq.size() >= TH));
        end
        check("dem_count", 32'(dut.w_count), 3);
        DACK = 1'b0;
        demandMode = 1'b0;

        // EOP during XFER: sticky TC, DREQ blocked until tcClear
        for (int i = 0; i < 3; i++) push_local(8'($urandom));
        wait_dreq("eop_dreq");
        DACK = 1'b1;
        tick();
        check("eop_state_xfer", 32'(dut.r_state), 32'(ST_XFER));
        EOP_N = 1'b0;
        tick();
        EOP_N = 1'b1;
        check("eop_tc", 32'(tcFlag), 1);
        check("eop_dreq", 32'(DREQ), 0);
        check("eop_state_done", 32'(dut.r_state), 32'(ST_DONE));
        DACK = 1'b0;
        repeat (3) tick();
        check("eop_dreq_held", 32'(DREQ), 0);
        tcClear = 1'b1;
        tick();
        tcClear = 1'b0;
        check("tcclr_flag", 32'(tcFlag), 0);
        check("tcclr_state", 32'(dut.r_state), 32'(ST_IDLE));
        wait_dreq("tcclr_rearm");

        // Drain TX in order, then read an empty FIFO
        DACK = 1'b1;
        for (int i = 0; i < 6; i++) ior_pulse("drain");
        check("drain_count", 32'(dut.w_count), 0);
        ior_pulse("und");
        check("und_flag", 32'(errUnderrun), 32'(m_und));
        check("und_count", 32'(dut.w_count), 0);
        iow_pulse(8'h5A);
        check("tx_iow_ignored_ovr", 32'(errOverrun), 0);
        check("tx_iow_ignored_cnt", 32'(dut.w_count), 0);
        DACK = 1'b0;

        // RX: empty FIFO requests, bus writes fill it
        dirTx = 1'b0;
        #1;
        check("rx_devready", 32'(devReady), 0);
        wait_dreq("rx_dreq");
        DACK = 1'b1;
        iow_pulse(8'h11);
        iow_pulse(8'h22);
        iow_pulse(8'h33);
        check("rx_data", 32'(rxData), 32'(8'h11));
        check("rx_valid", 32'(rxValid), 1);
        check("rx_count", 32'(dut.w_count), 3);
        for (int i = 0; i < 13; i++) iow_pulse(8'($urandom));
        check("rx_full_count", 32'(dut.w_count), 16);
        check("rx_full_noovr", 32'(errOverrun), 0);

        // Bus push and local pop together at full: both happen, no overrun
        dbIn  = 8'($urandom);
        IOW_N = 1'b0;
        tick();
        IOW_N   = 1'b1;
        rxReady = 1'b1;
        tick();
        rxReady = 1'b0;
        void'(mq.pop_front());
        mq.push_back(dbIn);
        check("both_count", 32'(dut.w_count), 16);
        check("both_noovr", 32'(errOverrun), 0);

        iow_pulse(8'($urandom));
        check("ovr_flag", 32'(errOverrun), 32'(m_ovr));
        check("ovr_count", 32'(dut.w_count), 16);

        for (int i = 0; i < DEPTH; i++) begin
            check("rx_order", 32'(rxData), 32'(mq[0]));
            rxReady = 1'b1;
            tick();
            rxReady = 1'b0;
            void'(mq.pop_front());
        end
        check("rx_empty", 32'(rxValid), 0);

        // Asynchronous reset in the middle of a transfer
        demandMode = 1'b1;
        for (int i = 0; i < 5; i++) iow_pulse(8'($urandom));
        check("mid_count", 32'(dut.w_count), 5);
        check("mid_dreq", 32'(DREQ), 1);
        IOW_N = 1'b0;
        tick();
        check("mid_state", 32'(dut.r_state), 32'(ST_XFER));
        #2;
        RESET_N = 1'b0;
        #1;
        mq.delete();
        check("arst_dreq", 32'(DREQ), 0);
        check("arst_count", 32'(dut.w_count), 0);
        check("arst_state", 32'(dut.r_state), 32'(ST_IDLE));
        check("arst_tc", 32'(tcFlag), 0);
        check("arst_ovr", 32'(errOverrun), 0);
        check("arst_und", 32'(errUnderrun), 0);
        check("arst_rxvalid", 32'(rxValid), 0);
        IOW_N = 1'b1;
        DACK  = 1'b0;
        demandMode = 1'b0;
        tick();
        RESET_N = 1'b1;
        repeat (2) tick();
        check("post_rst_count", 32'(dut.w_count), 0);
        check("post_rst_ovr", 32'(errOverrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
